// File: rtl/divider_arbiter.sv
// Round-robin arbiter sharing one multi-cycle divider among NUM_REQ requesters.
// Latency: accept -> div_start next cycle -> rsp_valid the cycle after div_done (or TIMEOUT+1 after start).
// Backpressure: req_ready only asserted in IDLE; responses are single-cycle pulses with no backpressure.
module divider_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]      req_dividend,
  input  logic [NUM_REQ*WIDTH-1:0]      req_divisor,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
  output logic [WIDTH-1:0]              rsp_quotient,
  output logic [WIDTH-1:0]              rsp_remainder,
  output logic                          rsp_dbz,
  output logic                          rsp_timeout,
  output logic                          div_start,
  output logic [WIDTH-1:0]              div_dividend,
  output logic [WIDTH-1:0]              div_divisor,
  input  logic                          div_done,
  input  logic [WIDTH-1:0]              div_quotient,
  input  logic [WIDTH-1:0]              div_remainder
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   win;
  logic             win_vld;
  logic [IDW-1:0]   id_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic             dbz_q;
  logic             to_q;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             done_hit;
  logic             tmo_hit;
  logic [WIDTH-1:0] win_dividend;
  logic [WIDTH-1:0] win_divisor;

  // Requester index at offset k from the priority pointer, wrapping at NUM_REQ.
  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDW'(s);
  endfunction

  // Round-robin search: first valid requester starting at the pointer.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_vld && req_valid[rr_idx(ptr, k)]) begin
        win     = rr_idx(ptr, k);
        win_vld = 1'b1;
      end
    end
  end

  assign win_dividend = req_dividend[int'(win)*WIDTH +: WIDTH];
  assign win_divisor  = req_divisor[int'(win)*WIDTH +: WIDTH];

  // Done is only honoured in WAIT and beats a coincident timeout.
  assign accept   = (state == S_IDLE) && win_vld;
  assign done_hit = (state == S_WAIT) && div_done;
  assign tmo_hit  = (state == S_WAIT) && !div_done && (cnt == CW'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT:  if (done_hit || tmo_hit) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand/result latching, round-robin pointer and watchdog counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      id_q  <= '0;
      dvd_q <= '0;
      dvs_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dbz_q <= 1'b0;
      to_q  <= 1'b0;
      cnt   <= '0;
    end else begin
      if (accept) begin
        dvd_q <= win_dividend;
        dvs_q <= win_divisor;
        id_q  <= win;
        dbz_q <= (win_divisor == '0);
        ptr   <= (win == IDW'(NUM_REQ - 1)) ? '0 : win + IDW'(1);
      end
      if (state == S_START) begin
        cnt <= '0;
      end
      if (state == S_WAIT) begin
        cnt <= cnt + CW'(1);
        if (done_hit) begin
          quo_q <= div_quotient;
          rem_q <= div_remainder;
          to_q  <= 1'b0;
        end else if (tmo_hit) begin
          quo_q <= '0;
          rem_q <= '0;
          to_q  <= 1'b1;
        end
      end
    end
  end

  // Outputs: response fields are only driven during the RESP pulse.
  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && win_vld) req_ready[win] = 1'b1;
    div_start     = (state == S_START);
    div_dividend  = dvd_q;
    div_divisor   = dvs_q;
    rsp_valid     = (state == S_RESP);
    rsp_id        = rsp_valid ? id_q  : '0;
    rsp_quotient  = rsp_valid ? quo_q : '0;
    rsp_remainder = rsp_valid ? rem_q : '0;
    rsp_dbz       = rsp_valid && dbz_q;
    rsp_timeout   = rsp_valid && to_q;
  end

endmodule

// File: tb/tb_divider_arbiter.sv
// Directed bench for divider_arbiter with a behavioural divider stub.
// Stub latency D: done is high D cycles after the div_start cycle.
// Expected values are hand-computed constants in each test.
module tb_divider_arbiter;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int TMO = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_dividend;
  logic [N*W-1:0]   req_divisor;
  logic [N-1:0]     req_ready;
  logic             rsp_valid;
  logic [1:0]       rsp_id;
  logic [W-1:0]     rsp_quotient;
  logic [W-1:0]     rsp_remainder;
  logic             rsp_dbz;
  logic             rsp_timeout;
  logic             div_start;
  logic [W-1:0]     div_dividend;
  logic [W-1:0]     div_divisor;
  logic             div_done = 1'b0;
  logic [W-1:0]     div_quotient = '0;
  logic [W-1:0]     div_remainder = '0;

  divider_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_dividend(req_dividend), .req_divisor(req_divisor),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_quotient(rsp_quotient),
    .rsp_remainder(rsp_remainder), .rsp_dbz(rsp_dbz), .rsp_timeout(rsp_timeout),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Divider stub: zero divisor yields all-ones quotient and dividend as remainder.
  int          stub_lat = 3;
  int          scnt = 0;
  int          n_done = 0;
  logic [W-1:0] sa = '0;
  logic [W-1:0] sb = '0;
  always @(posedge clk) begin
    div_done <= 1'b0;
    if (div_start) begin
      sa   <= div_dividend;
      sb   <= div_divisor;
      scnt <= stub_lat - 1;
    end else if (scnt > 0) begin
      scnt <= scnt - 1;
      if (scnt == 1) begin
        div_done      <= 1'b1;
        div_quotient  <= (sb == 0) ? '1 : sa / sb;
        div_remainder <= (sb == 0) ? sa : sa % sb;
        n_done        <= n_done + 1;
      end
    end
  end

  typedef struct {
    int         id;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic       dbz;
    logic       to;
    int         cyc;
  } rsp_t;

  rsp_t rsp_log[$];
  int   n_start = 0;
  int   start_cyc = 0;

  // Response and start monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rsp_valid)
      rsp_log.push_back('{int'(rsp_id), rsp_quotient, rsp_remainder, rsp_dbz, rsp_timeout, cyc});
    if (div_start) begin
      n_start++;
      start_cyc = cyc;
    end
  end

  int n_vec = 0;
  int n_err = 0;
  bit hold_valid = 1'b0;
  int gq[$];
  int acc_cyc[N];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: record accepts, then drop accepted valids unless holding.
  task automatic tick();
    logic [N-1:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        gq.push_back(i);
        acc_cyc[i] = cyc;
      end
    end
    @(posedge clk);
    #1;
    if (!hold_valid) req_valid = req_valid & ~acc;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_dividend[i*W +: W] = a;
    req_divisor[i*W +: W]  = b;
    req_valid[i]           = 1'b1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
    rsp_log.delete();
    gq.delete();
    n_start = 0;
  endtask

  task automatic get_rsp(output rsp_t r);
    int n;
    n = 0;
    while (rsp_log.size() == 0 && n < 60) begin
      tick();
      n++;
    end
    check_eq("rsp_arrived", 64'(rsp_log.size() != 0), 64'd1);
    if (rsp_log.size() != 0) r = rsp_log.pop_front();
    else                     r = '{-1, '0, '0, 1'b0, 1'b0, 0};
  endtask

  initial begin
    rsp_t r1;
    rsp_t r2;
    int   n;
    int   nd;

    rst          = 1'b1;
    req_valid    = '0;
    req_dividend = '0;
    req_divisor  = '0;

    // Reset state
    do_reset();
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_id", rsp_id, 0);
    check_eq("rst_rsp_q", rsp_quotient, 0);
    check_eq("rst_rsp_r", rsp_remainder, 0);
    check_eq("rst_rsp_flags", {rsp_dbz, rsp_timeout}, 0);
    check_eq("rst_div_start", div_start, 0);
    check_eq("rst_div_opnds", {div_dividend, div_divisor}, 0);

    // Single request 10/7
    set_req(0, 10, 7);
    get_rsp(r1);
    check_eq("single_id", r1.id, 0);
    check_eq("single_q", r1.q, 1);
    check_eq("single_r", r1.r, 3);
    check_eq("single_flags", {r1.dbz, r1.to}, 0);
    check_eq("single_start_cycles", n_start, 1);
    check_eq("single_start_lat", start_cyc - acc_cyc[0], 1);
    check_eq("single_rsp_lat", r1.cyc - acc_cyc[0], 5);

    // Simultaneous requests on 0 and 2
    do_reset();
    set_req(0, 100, 100);
    set_req(2, 100, 7);
    get_rsp(r1);
    get_rsp(r2);
    check_eq("simul_id0", r1.id, 0);
    check_eq("simul_q0", r1.q, 1);
    check_eq("simul_r0", r1.r, 0);
    check_eq("simul_id1", r2.id, 2);
    check_eq("simul_q1", r2.q, 14);
    check_eq("simul_r1", r2.r, 2);
    check_eq("simul_grant2_after_resp", acc_cyc[2], r1.cyc + 1);

    // Fairness with all requesters continuously valid
    do_reset();
    hold_valid = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 40 + i, i + 1);
    n = 0;
    while (gq.size() < 6 && n < 200) begin
      tick();
      n++;
    end
    hold_valid = 1'b0;
    req_valid  = '0;
    check_eq("fair_grant_count", 64'(gq.size() >= 6), 64'd1);
    for (int k = 0; k < 6; k++)
      check_eq($sformatf("fair_grant%0d", k), (gq.size() > k) ? gq[k] : -1, k % N);
    repeat (12) tick();

    // Zero divisor on req1, then req3 70/150
    do_reset();
    set_req(1, 100, 0);
    set_req(3, 70, 150);
    get_rsp(r1);
    get_rsp(r2);
    check_eq("dbz_id", r1.id, 1);
    check_eq("dbz_flag", r1.dbz, 1);
    check_eq("dbz_q", r1.q, 32'hFFFF_FFFF);
    check_eq("dbz_r", r1.r, 100);
    check_eq("after_dbz_id", r2.id, 3);
    check_eq("after_dbz_q", r2.q, 0);
    check_eq("after_dbz_r", r2.r, 70);
    check_eq("after_dbz_flag", r2.dbz, 0);

    // Timeout: stub answers only 12 cycles after start
    do_reset();
    stub_lat = 12;
    set_req(0, 50, 5);
    get_rsp(r1);
    check_eq("tmo_flag", r1.to, 1);
    check_eq("tmo_q", r1.q, 0);
    check_eq("tmo_r", r1.r, 0);
    check_eq("tmo_rsp_lat", r1.cyc - start_cyc, TMO + 1);
    nd = n_done;
    n  = 0;
    while (n_done == nd && n < 20) begin
      tick();
      n++;
    end
    check_eq("tmo_late_done_seen", 64'(n_done != nd), 64'd1);
    tick();
    check_eq("tmo_late_done_ignored", rsp_log.size(), 0);
    stub_lat = 3;
    set_req(1, 9, 2);
    get_rsp(r1);
    check_eq("post_tmo_id", r1.id, 1);
    check_eq("post_tmo_q", r1.q, 4);
    check_eq("post_tmo_r", r1.r, 1);
    check_eq("post_tmo_flag", r1.to, 0);

    // Reset while waiting on the divider
    do_reset();
    stub_lat = 12;
    set_req(0, 20, 3);
    n = 0;
    while (n_start == 0 && n < 20) begin
      tick();
      n++;
    end
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midrst_req_ready", req_ready, 0);
    check_eq("midrst_rsp_valid", rsp_valid, 0);
    check_eq("midrst_div_start", div_start, 0);
    check_eq("midrst_div_opnds", {div_dividend, div_divisor}, 0);
    repeat (14) tick();
    check_eq("midrst_no_rsp", rsp_log.size(), 0);
    stub_lat = 3;
    set_req(0, 5, 5);
    set_req(3, 10, 7);
    get_rsp(r1);
    get_rsp(r2);
    check_eq("midrst_ptr_id", r1.id, 0);
    check_eq("midrst_q0", r1.q, 1);
    check_eq("midrst_id3", r2.id, 3);
    check_eq("midrst_q3", r2.q, 1);
    check_eq("midrst_r3", r2.r, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
